// File: rtl/lotr_pkg.sv
// LOTR ring shared types: opcodes, the ring slot packet and the read-return tag.
// Also holds the default local FIFO depth and the slot-addressing helper.
package lotr_pkg;

  typedef enum logic [1:0] {
    NOP    = 2'd0,
    RD     = 2'd1,
    WR     = 2'd2,
    RD_RSP = 2'd3
  } t_opcode;

  typedef struct packed {
    logic        valid;
    t_opcode     opcode;
    logic [7:0]  src_core;
    logic [1:0]  thread;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_pkt;

  // Who to send a read response back to once the tile answers.
  typedef struct packed {
    logic [7:0] core;
    logic [1:0] thread;
  } t_tag;

  localparam int RING_FIFO_DEPTH = 4;

  // Requests are routed by the top address byte; responses by their source core.
  function automatic logic isLocalReq(t_ring_pkt pkt, logic [7:0] id);
    return pkt.valid && (pkt.opcode == RD || pkt.opcode == WR) && (pkt.address[31:24] == id);
  endfunction

endpackage

// File: rtl/rc_ring_stop_if.sv
// Tile-side bundle between gpc_4t and its ring stop: C2F requests/responses, F2C requests/responses.
// master = tile, slave = ring stop.
interface rc_ring_stop_if;
  import lotr_pkg::*;

  logic        C2F_ReqValidQ500H;
  t_opcode     C2F_ReqOpcodeQ500H;
  logic [1:0]  C2F_ReqThreadIDQ500H;
  logic [31:0] C2F_ReqAddressQ500H;
  logic [31:0] C2F_ReqDataQ500H;

  logic        C2F_RspValidQ502H;
  t_opcode     C2F_RspOpcodeQ502H;
  logic [1:0]  C2F_RspThreadIDQ502H;
  logic [31:0] C2F_RspDataQ502H;
  logic        C2F_RspStall;

  logic        F2C_ReqValidQ502H;
  t_opcode     F2C_ReqOpcodeQ502H;
  logic [31:0] F2C_ReqAddressQ502H;
  logic [31:0] F2C_ReqDataQ502H;

  logic        F2C_RspValidQ500H;
  t_opcode     F2C_RspOpcodeQ500H;
  logic [31:0] F2C_RspAddressQ500H;
  logic [31:0] F2C_RspDataQ500H;

  modport master (
    output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
           C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
    output F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H,
    input  C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspThreadIDQ502H, C2F_RspDataQ502H,
    input  C2F_RspStall,
    input  F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H
  );

  modport slave (
    input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
           C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
    input  F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H,
    output C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspThreadIDQ502H, C2F_RspDataQ502H,
    output C2F_RspStall,
    output F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H
  );

endinterface

// File: rtl/lotr_sync_fifo.sv
// Show-ahead synchronous FIFO: push visible at head the cycle after; pop is same-cycle.
// A push to a full FIFO is dropped unless that FIFO is popped in the same cycle.
`ifndef LOTR_MSFF
`define LOTR_MSFF(q, d, clk) always_ff @(posedge clk) q <= d;
`endif
`ifndef LOTR_RST_MSFF
`define LOTR_RST_MSFF(q, d, clk, rst, rv) always_ff @(posedge clk) if (rst) q <= rv; else q <= d;
`endif

module lotr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pushValid,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     popValid,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] memD [DEPTH];
  logic [PTR_W-1:0] wrPtr, wrPtrD, rdPtr, rdPtrD;
  logic [CNT_W-1:0] countD;
  logic             doPush, doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = popValid && !empty;
  assign doPush  = pushValid && (!full || doPop);
  assign popData = mem[rdPtr];

  always_comb begin
    memD = mem;
    if (doPush) memD[wrPtr] = pushData;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  assign wrPtrD = doPush ? wrPtr + PTR_W'(1) : wrPtr;
  assign rdPtrD = doPop  ? rdPtr + PTR_W'(1) : rdPtr;

  always_comb begin
    unique case ({doPush, doPop})
      2'b10:   countD = count + CNT_W'(1);
      2'b01:   countD = count - CNT_W'(1);
      default: countD = count;
    endcase
  end

  `LOTR_MSFF(mem, memD, clk)
  `LOTR_RST_MSFF(wrPtr, wrPtrD, clk, rst, '0)
  `LOTR_RST_MSFF(rdPtr, rdPtrD, clk, rst, '0)
  `LOTR_RST_MSFF(count, countD, clk, rst, '0)

endmodule

// File: rtl/rc_ring_stop.sv
// LOTR ring stop for one gpc_4t tile: ejects local traffic, forwards the rest, injects into free slots; 2-cycle Q500H->Q502H.
// Local reads bounce when tag+response queues are full; C2F_RspStall throttles the tile one entry early.
`ifndef LOTR_MSFF
`define LOTR_MSFF(q, d, clk) always_ff @(posedge clk) q <= d;
`endif
`ifndef LOTR_RST_MSFF
`define LOTR_RST_MSFF(q, d, clk, rst, rv) always_ff @(posedge clk) if (rst) q <= rv; else q <= d;
`endif

module rc_ring_stop
  import lotr_pkg::*;
#(
  parameter int FIFO_DEPTH = RING_FIFO_DEPTH
) (
  input  logic          QClk,
  input  logic          RstQnnnH,
  input  logic [7:0]    CoreID,
  input  t_ring_pkt     RingInQ500H,
  output t_ring_pkt     RingOutQ502H,
  rc_ring_stop_if.slave tileIf
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PKT_W = $bits(t_ring_pkt);
  localparam int TAG_W = $bits(t_tag);

  t_ring_pkt        slotQ501H, ringOutD;
  t_ring_pkt        reqHead, rspHead, reqPushPkt, rspPushPkt;
  t_tag             tagHead, tagPushDat;
  logic [PKT_W-1:0] reqHeadRaw, rspHeadRaw;
  logic [TAG_W-1:0] tagHeadRaw;
  logic [CNT_W-1:0] reqCount, rspCount, tagCount;
  logic             reqFull, rspFull, tagFull;
  logic             reqEmpty, rspEmpty, tagEmpty;
  logic             reqPush, reqPop, rspPush, rspPop, tagPush, tagPop;

  logic             slotIsReq, slotIsRsp, rdRoom, ejectReq, ejectRsp, slotFree;
  logic             injRsp, injReq, stallD;

  logic             f2cReqVld, c2fRspVld, stallQ;
  t_opcode          f2cReqOp, c2fRspOp;
  logic [31:0]      f2cReqAddr, f2cReqData, c2fRspData;
  logic [1:0]       c2fRspThread;
  logic             unusedSig;

  `LOTR_RST_MSFF(slotQ501H, RingInQ500H, QClk, RstQnnnH, '0)

  // ---------------- slot decision at Q501H ----------------
  assign slotIsReq = isLocalReq(slotQ501H, CoreID);
  assign slotIsRsp = slotQ501H.valid && (slotQ501H.opcode == RD_RSP) && (slotQ501H.src_core == CoreID);

  // A read is only taken if its eventual response is guaranteed a RspFifo entry.
  assign rdRoom   = ((CNT_W+1)'(tagCount) + (CNT_W+1)'(rspCount)) < (CNT_W+1)'(FIFO_DEPTH);
  assign ejectReq = slotIsReq && ((slotQ501H.opcode == WR) || rdRoom);
  assign ejectRsp = slotIsRsp;
  assign slotFree = !slotQ501H.valid || ejectReq || ejectRsp;

  // Responses first: they drain remote requesters and so can never be blocked by requests.
  assign injRsp = slotFree && !rspEmpty;
  assign injReq = slotFree && rspEmpty && !reqEmpty;

  always_comb begin
    ringOutD = slotFree ? '0 : slotQ501H;
    if (injRsp)      ringOutD = rspHead;
    else if (injReq) ringOutD = reqHead;
  end

  // ---------------- local queues ----------------
  assign reqPush    = tileIf.C2F_ReqValidQ500H;
  assign reqPop     = injReq;
  assign reqPushPkt = '{valid:    1'b1,
                        opcode:   tileIf.C2F_ReqOpcodeQ500H,
                        src_core: CoreID,
                        thread:   tileIf.C2F_ReqThreadIDQ500H,
                        address:  tileIf.C2F_ReqAddressQ500H,
                        data:     tileIf.C2F_ReqDataQ500H};

  assign tagPush    = ejectReq && (slotQ501H.opcode == RD);
  assign tagPop     = tileIf.F2C_RspValidQ500H && !tagEmpty;
  assign tagPushDat = '{core: slotQ501H.src_core, thread: slotQ501H.thread};

  assign rspPush    = tagPop;
  assign rspPop     = injRsp;
  assign rspPushPkt = '{valid:    1'b1,
                        opcode:   RD_RSP,
                        src_core: tagHead.core,
                        thread:   tagHead.thread,
                        address:  tileIf.F2C_RspAddressQ500H,
                        data:     tileIf.F2C_RspDataQ500H};

  assign reqHead = t_ring_pkt'(reqHeadRaw);
  assign rspHead = t_ring_pkt'(rspHeadRaw);
  assign tagHead = t_tag'(tagHeadRaw);

  lotr_sync_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) ReqFifo (
    .clk(QClk), .rst(RstQnnnH),
    .pushValid(reqPush), .pushData(reqPushPkt),
    .popValid(reqPop), .popData(reqHeadRaw),
    .count(reqCount), .full(reqFull), .empty(reqEmpty)
  );

  lotr_sync_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) RspFifo (
    .clk(QClk), .rst(RstQnnnH),
    .pushValid(rspPush), .pushData(rspPushPkt),
    .popValid(rspPop), .popData(rspHeadRaw),
    .count(rspCount), .full(rspFull), .empty(rspEmpty)
  );

  lotr_sync_fifo #(.WIDTH(TAG_W), .DEPTH(FIFO_DEPTH)) TagFifo (
    .clk(QClk), .rst(RstQnnnH),
    .pushValid(tagPush), .pushData(tagPushDat),
    .popValid(tagPop), .popData(tagHeadRaw),
    .count(tagCount), .full(tagFull), .empty(tagEmpty)
  );

  // One entry of slack covers a request the tile issued before it saw the stall.
  assign stallD = (reqCount >= CNT_W'(FIFO_DEPTH - 1));

  // ---------------- Q502H outputs ----------------
  `LOTR_RST_MSFF(RingOutQ502H, ringOutD, QClk, RstQnnnH, '0)
  `LOTR_RST_MSFF(f2cReqVld,    ejectReq,            QClk, RstQnnnH, 1'b0)
  `LOTR_RST_MSFF(f2cReqOp,     slotQ501H.opcode,    QClk, RstQnnnH, NOP)
  `LOTR_RST_MSFF(f2cReqAddr,   slotQ501H.address,   QClk, RstQnnnH, '0)
  `LOTR_RST_MSFF(f2cReqData,   slotQ501H.data,      QClk, RstQnnnH, '0)
  `LOTR_RST_MSFF(c2fRspVld,    ejectRsp,            QClk, RstQnnnH, 1'b0)
  `LOTR_RST_MSFF(c2fRspOp,     slotQ501H.opcode,    QClk, RstQnnnH, NOP)
  `LOTR_RST_MSFF(c2fRspThread, slotQ501H.thread,    QClk, RstQnnnH, '0)
  `LOTR_RST_MSFF(c2fRspData,   slotQ501H.data,      QClk, RstQnnnH, '0)
  `LOTR_RST_MSFF(stallQ,       stallD,              QClk, RstQnnnH, 1'b0)

  assign tileIf.F2C_ReqValidQ502H    = f2cReqVld;
  assign tileIf.F2C_ReqOpcodeQ502H   = f2cReqOp;
  assign tileIf.F2C_ReqAddressQ502H  = f2cReqAddr;
  assign tileIf.F2C_ReqDataQ502H     = f2cReqData;
  assign tileIf.C2F_RspValidQ502H    = c2fRspVld;
  assign tileIf.C2F_RspOpcodeQ502H   = c2fRspOp;
  assign tileIf.C2F_RspThreadIDQ502H = c2fRspThread;
  assign tileIf.C2F_RspDataQ502H     = c2fRspData;
  assign tileIf.C2F_RspStall         = stallQ;

  // The tile only ever returns read data, so its response opcode carries nothing.
  assign unusedSig = ^{tileIf.F2C_RspOpcodeQ500H, reqFull, rspFull, tagFull};

endmodule

// File: doc/rc_ring_stop.md
# rc_ring_stop

Ring stop that attaches one gpc_4t tile to the LOTR ring. Every cycle it samples one ring slot and decides per slot. Packets addressed to this core are ejected into the tile's F2C request and C2F response ports. Other packets are forwarded. Locally originated C2F requests and F2C responses are injected into free slots. It sits directly between gpc_4t's Q500H/Q502H ports and the neighbouring ring stops.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries in each local injection/tag FIFO (power of 2, ≥2)

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  reset; one clock, synchronous, active-high
- CoreID  in  8  this tile's ID strap
- RingInQ500H  in  t_ring_pkt  slot from upstream stop (valid, opcode, src_core[7:0], thread[1:0], address[31:0], data[31:0])
- RingOutQ502H  out  t_ring_pkt  slot to downstream stop
- C2F_ReqValidQ500H / OpcodeQ500H / ThreadIDQ500H / AddressQ500H / DataQ500H  in  1/t_opcode/2/32/32  tile-originated request
- C2F_RspValidQ502H / OpcodeQ502H / ThreadIDQ502H / DataQ502H  out  1/t_opcode/2/32  response returned to tile
- C2F_RspStall  out  1  tile must stop issuing C2F requests
- F2C_ReqValidQ502H / OpcodeQ502H / AddressQ502H / DataQ502H  out  1/t_opcode/32/32  remote access into tile memory
- F2C_RspValidQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  in  1/t_opcode/32/32  tile's read response

## Operation
Capture:
- RingInQ500H is flopped to Q501H.
- Tile C2F request valid pushes {RD|WR, src=CoreID, thread, addr, data} into ReqFifo.
- Tile F2C response valid pops TagFifo and pushes {RD_RSP, src=tag.core, thread=tag.thread, addr, data} into RspFifo.

Slot decision at Q501H:
- Request (RD/WR) with address[31:24]==CoreID is ejected to F2C_Req*Q502H.
  - RD additionally pushes {src_core, thread} into TagFifo.
  - RD is ejected only if TagFifo count + RspFifo count < FIFO_DEPTH. Otherwise it is bounced: forwarded unchanged and retried on the next ring lap.
  - WR always ejects; it produces no response.
- RD_RSP with src_core==CoreID is ejected to C2F_Rsp*Q502H with its opcode, thread and data.
- Anything else valid is forwarded to RingOutQ502H unchanged.

Injection into an empty or just-ejected slot:
- RspFifo head has priority over ReqFifo head. This prevents deadlock.
- At most one injection per cycle.

C2F_RspStall is registered and equals ReqFifo count ≥ FIFO_DEPTH-1. This leaves one entry of margin for a request already in flight.

Protocol errors are illegal, and the bench asserts on each:
- push to a full ReqFifo or RspFifo;
- F2C response while TagFifo is empty.

## Timing
- Reset (synchronous, checked on QClk rise):
  - all valid outputs are 0; RingOutQ502H is all-zero;
  - C2F_RspStall = 0;
  - all FIFOs are empty.
  - Reset mid-operation discards every queued or in-flight packet.
- Ring pass-through latency: 2 cycles (Q500H → Q502H).
- Ejection latency: 2 cycles (ring Q500H → F2C_Req/C2F_Rsp Q502H).
- Injection latency, request into an idle ring:
  - C2F_Req at cycle N is pushed into ReqFifo at N+1;
  - it is injected on RingOutQ502H at N+2 (same Q501H decision cycle as the FIFO head becomes visible).
- A response from the tile is injected no earlier than 2 cycles after F2C_RspValidQ500H.
- Eject and inject in the same slot in the same cycle is legal.
- A FIFO push and pop in the same cycle keeps the count; a FIFO that is simultaneously full and popped accepts the push.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.

## Structure
- lotr_pkg gains:
  - t_ring_pkt packed struct;
  - RD, WR, RD_RSP values in t_opcode (already present: reuse);
  - localparam RING_FIFO_DEPTH = 4.
- Sub-module lotr_sync_fifo (parameterised width/depth; count/full/empty outputs) is instantiated three times: ReqFifo, RspFifo, TagFifo.
- Flops use the LOTR_MSFF / LOTR_RST_MSFF macros.

## Test plan
- Reset during traffic: fill ReqFifo with 3 entries, pulse RstQnnnH for 1 cycle → next cycle all valids 0 and C2F_RspStall=0; no injection afterwards.
- Pass-through: CoreID=0x02, ring RD to addr 0x0500_0010 at cycle 0 → identical pkt on RingOutQ502H at cycle 2; no F2C_Req.
- Local read round trip: ring RD addr 0x0200_0040, src 0x07, thread 3 → F2C_ReqValidQ502H at cycle 2. Tile returns data 0xDEADBEEF at cycle 5 → RingOutQ502H RD_RSP src 0x07 thread 3 data 0xDEADBEEF at cycle 7.
- Response ejection with same-slot injection: ReqFifo holds 1 entry; ring RD_RSP src==CoreID thread 1 arrives → C2F_Rsp thread 1 and the injected request both appear on cycle 2.
- Backpressure: issue 3 back-to-back C2F requests while the ring is full of foreign traffic → C2F_RspStall rises 1 cycle after the third push; it drops after the first free slot injects.
- Bounce: TagFifo+RspFifo count at 4, ring RD to this core → forwarded unchanged, no F2C_Req; a WR to this core in the same state → ejected.
